// File: rtl/signed_carry_select_adder.sv
// rtl/signed_carry_select_adder.sv - registered signed carry-select adder with overflow flag
//
// Purpose: computes (A + B + Cin) mod 2^WIDTH using a carry-select structure
// built from BLOCK-bit ripple-carry slices. It also flags signed
// two's-complement overflow. Both results are registered, giving one cycle of
// latency and one addition per cycle.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset, clears sum_out and overflow
//   A, B     - WIDTH-bit signed operands
//   Cin      - carry into bit 0 (drive B = ~operand, Cin = 1 for subtract)
//   sum_out  - registered (A + B + Cin) mod 2^WIDTH
//   overflow - registered signed-overflow flag for the same addition
module signed_carry_select_adder #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum_out,
  output logic             overflow
);

  localparam int NBLK = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_width
    $error("WIDTH must be a non-zero multiple of BLOCK");
  end

  // Ripple-carry slice made of full adders.
  // Result packing: {carry into slice MSB, carry out, sum[BLOCK-1:0]}.
  function automatic logic [BLOCK+1:0] rca(input logic [BLOCK-1:0] a,
                                           input logic [BLOCK-1:0] b,
                                           input logic             ci);
    logic             c;
    logic             cm;
    logic [BLOCK-1:0] s;
    c  = ci;
    cm = ci;
    s  = '0;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == BLOCK - 1) cm = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {cm, c, s};
  endfunction

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;   // selected carry out of the block processed so far
  logic             cmsb_c;    // selected carry into the overall MSB
  logic [BLOCK+1:0] spec0;     // speculative slice result, carry-in 0
  logic [BLOCK+1:0] spec1;     // speculative slice result, carry-in 1
  logic [BLOCK+1:0] chosen;

  // Block 0 ripples directly from Cin. Each higher block computes both
  // speculative results, and the previous block's selected carry picks one.
  // After the loop, cmsb_c holds the MSB block's internal carry.
  always_comb begin
    sum_c   = '0;
    carry_c = Cin;
    cmsb_c  = Cin;
    spec0   = '0;
    spec1   = '0;
    chosen  = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (k == 0) begin
        chosen = rca(A[0 +: BLOCK], B[0 +: BLOCK], Cin);
      end else begin
        spec0  = rca(A[k*BLOCK +: BLOCK], B[k*BLOCK +: BLOCK], 1'b0);
        spec1  = rca(A[k*BLOCK +: BLOCK], B[k*BLOCK +: BLOCK], 1'b1);
        chosen = carry_c ? spec1 : spec0;
      end
      sum_c[k*BLOCK +: BLOCK] = chosen[BLOCK-1:0];
      carry_c                 = chosen[BLOCK];
      cmsb_c                  = chosen[BLOCK+1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_out  <= '0;
      overflow <= 1'b0;
    end else begin
      sum_out  <= sum_c;
      overflow <= cmsb_c ^ carry_c;
    end
  end

endmodule

// File: tb/tb_signed_carry_select_adder.sv
// tb/tb_signed_carry_select_adder.sv - self-checking bench for signed_carry_select_adder
module tb_signed_carry_select_adder;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] sum_out;
  logic       overflow;

  int checks;
  int failures;

  signed_carry_select_adder #(.WIDTH(8), .BLOCK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .sum_out  (sum_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the signed values.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    int sa;
    int sb;
    int total;
    int raw;
    logic ov;
    sa    = $signed(a);
    sb    = $signed(b);
    total = sa + sb + int'(c);
    ov    = (total > 127) || (total < -128);
    raw   = (int'(a) + int'(b) + int'(c)) % 256;
    return {ov, raw[7:0]};
  endfunction

  // Drive operands away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_sum, input logic exp_ov, input string tag);
    @(negedge clk);
    A = a; B = b; Cin = c;
    @(posedge clk);
    #1;
    check({tag, ".sum"}, 16'(sum_out), 16'(exp_sum));
    check({tag, ".ovf"}, 16'(overflow), 16'(exp_ov));
  endtask

  initial begin
    logic [8:0] r;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    A = 8'h55; B = 8'h22; Cin = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset.sum", 16'(sum_out), 16'h00);
      check("reset.ovf", 16'(overflow), 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release.sum", 16'(sum_out), 16'h77);
    check("release.ovf", 16'(overflow), 16'h0);

    step(8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, "wrap");
    step(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "negneg");
    step(8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, "maxpos");
    step(8'hFE, 8'hFE, 1'b0, 8'hFC, 1'b0, "m2m2");
    step(8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, "blkcarry");

    // Input changes between edges must not reach the outputs.
    #2;
    A = 8'h33; B = 8'h44; Cin = 1'b1;
    #1;
    check("hold.sum", 16'(sum_out), 16'h10);
    check("hold.ovf", 16'(overflow), 16'h0);

    step(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "b2b0");
    step(8'h40, 8'h40, 1'b0, 8'h80, 1'b1, "b2b1");
    step(8'hC0, 8'hC0, 1'b0, 8'h80, 1'b0, "b2b2");
    step(8'h10, 8'hEF, 1'b1, 8'h00, 1'b0, "b2b3");

    // Mid-stream reset discards the sampled operation.
    step(8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b1, "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    A = 8'h12; B = 8'h34; Cin = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.sum", 16'(sum_out), 16'h00);
    check("midrst.ovf", 16'(overflow), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.sum", 16'(sum_out), 16'h47);
    check("post_rst.ovf", 16'(overflow), 16'h0);

    for (int n = 0; n < 1200; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      r  = ref_add(ra, rb, rc);
      step(ra, rb, rc, r[7:0], r[8], "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signed_carry_select_adder.md
Name: signed_carry_select_adder

Overview:
- Signed two's-complement adder, WIDTH bits wide, built with a carry-select architecture.
- Computes A + B + Cin and flags signed overflow.
- Outputs are registered, so the block is a single-stage pipelined arithmetic element for the 8-bit CPU datapath (ALU add/subtract path).
- Subtraction is done by the caller: drive B = ~operand and Cin = 1.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of BLOCK.
- BLOCK, 4, bit width of each carry-select block.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- A  input  WIDTH  signed two's-complement operand A.
- B  input  WIDTH  signed two's-complement operand B.
- Cin  input  1  carry-in to bit 0.
- sum_out  output  WIDTH  registered result (A + B + Cin) mod 2^WIDTH.
- overflow  output  1  registered signed-overflow flag for the same addition.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset: on a rising clk edge with rst_n = 0, sum_out <= 0 and overflow <= 0. Reset has priority over the inputs.
- Normal operation: on each rising clk edge with rst_n = 1, inputs are sampled and the result is registered.
  - Latency is 1 cycle; throughput is one addition per cycle.
  - There is no handshake and no enable.
- Arithmetic: sum_out = (A + B + Cin) mod 2^WIDTH. The carry out of the MSB is discarded and is not a port.
- Overflow:
  - overflow = carry into the MSB XOR carry out of the MSB.
  - Equivalently, overflow = 1 when A[MSB] == B[MSB] and sum[MSB] != A[MSB].
  - Cin is included in the carry chain when computing overflow.
- Carry-select structure (combinational, ahead of the output registers):
  - Block 0 (bits BLOCK-1:0): single ripple-carry adder with carry-in = Cin.
  - Every higher block k: two ripple-carry adders computed in parallel, one with carry-in 0 and one with carry-in 1, each producing a sum slice and a carry out.
  - A 2:1 mux selects block k's sum slice and carry out using the selected carry out of block k-1.
  - The MSB block also exposes its internal carry into the MSB (for both speculative versions, selected the same way) for the overflow computation.
  - Bit-level adders are full adders: s = a^b^c, co = ab | c(a^b).
- Boundary conditions:
  - Carry rippling across a block boundary (e.g. 0x0F + 0x00 + 1) must select the carry-in-1 upper sum.
  - Full wrap (0xFF + 0x00 + 1) yields 0x00 with overflow 0.
  - Most-negative + most-negative (0x80 + 0x80) yields 0x00 with overflow 1.
  - Most-positive + 1 (0x7F + 0x01) yields 0x80 with overflow 1.
  - Inputs changing between edges have no effect on outputs until the next edge.
  - Asserting rst_n = 0 mid-stream clears both outputs at that edge, discarding the sampled operation. The first edge after rst_n returns to 1 registers a fresh result.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

Test Plan:
- Hold rst_n = 0 for 2 edges with A = 0x55, B = 0x22 -> sum_out = 0x00, overflow = 0. Release reset -> next edge sum_out = 0x77, overflow = 0.
- A = 0xFF, B = 0x00, Cin = 1 (-1 - (-1)) -> one cycle later sum_out = 0x00, overflow = 0.
- A = 0x80, B = 0x80, Cin = 0 -> sum_out = 0x00, overflow = 1. Then A = 0x7F, B = 0x01, Cin = 0 -> sum_out = 0x80, overflow = 1.
- A = 0xFE, B = 0xFE, Cin = 0 (-2 + -2) -> sum_out = 0xFC, overflow = 0. Then A = 0x0F, B = 0x00, Cin = 1 -> sum_out = 0x10, overflow = 0 (block-boundary carry select).
- Back-to-back new operands every cycle for 4 cycles (0x01+0x01, 0x40+0x40, 0xC0+0xC0, 0x10+0xEF+1):
  - Expected outputs, each one cycle later: 0x02/0, 0x80/1, 0x80/0, 0x00/0.
  - Then drop rst_n for one edge -> 0x00/0.
- Randomized sweep, ≥1000 vectors against a reference model sum = (A+B+Cin) & 0xFF, overflow by the sign rule, checked with 1-cycle delay.
